// File: rtl/cpu_hlr.sv
// Multicycle 16-bit accumulator CPU with register-file instruction memory
// (reset to a built-in program) and an unreset data memory.
module cpu_hlr #(
  parameter int DW         = 16,
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 256,
  parameter int PCW        = $clog2(IMEM_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_sig,
  input  logic           imem_we,
  input  logic [PCW-1:0] imem_waddr,
  input  logic [DW-1:0]  imem_wdata,
  input  logic [7:0]     dbg_addr,
  output logic [DW-1:0]  dbg_data,
  output logic           busy,
  output logic           done,
  output logic [PCW-1:0] pc,
  output logic [DW-1:0]  acc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JN   = 4'hB;
  localparam logic [3:0] OP_ADDI = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SHR  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Built-in program: sums 10..1 into dmem[0x10] and leaves the sum in acc.
  function automatic logic [DW-1:0] default_word(input int idx);
    logic [DW-1:0] w;
    case (idx)
      32'd0:   w = 16'h1001;
      32'd1:   w = 16'h3012;
      32'd2:   w = 16'h100A;
      32'd3:   w = 16'h3011;
      32'd4:   w = 16'h1000;
      32'd5:   w = 16'h3010;
      32'd6:   w = 16'h2010;
      32'd7:   w = 16'h4011;
      32'd8:   w = 16'h3010;
      32'd9:   w = 16'h2011;
      32'd10:  w = 16'h5012;
      32'd11:  w = 16'h3011;
      32'd12:  w = 16'hA00E;
      32'd13:  w = 16'h9006;
      32'd14:  w = 16'h2010;
      32'd15:  w = 16'hF000;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  state_t         state_r, state_nxt_s;
  logic [PCW-1:0] pc_r, pc_nxt_s;
  logic [DW-1:0]  acc_r, acc_nxt_s;
  // ir keeps only opcode and operand; bits [11:8] of the word are don't-care.
  logic [11:0]    ir_r, ir_nxt_s;
  logic           busy_r, done_r;
  logic           dmem_we_s;
  logic           imem_wr_ok_s;
  logic [3:0]     opcode_s;
  logic [7:0]     oper_s;
  logic [DW-1:0]  dmem_rd_s;
  logic [DW-1:0]  fetch_word_s;

  logic [DW-1:0]  imem_r [IMEM_DEPTH];
  logic [DW-1:0]  dmem_r [DMEM_DEPTH];

  assign opcode_s     = ir_r[11:8];
  assign oper_s       = ir_r[7:0];
  assign dmem_rd_s    = dmem_r[oper_s];
  assign fetch_word_s = imem_r[pc_r];
  assign imem_wr_ok_s = (state_r == ST_IDLE) || (state_r == ST_HALT);

  // Next-state, datapath and data-memory write decode.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    acc_nxt_s   = acc_r;
    ir_nxt_s    = ir_r;
    dmem_we_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_sig) begin
          pc_nxt_s    = {PCW{1'b0}};
          acc_nxt_s   = {DW{1'b0}};
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ir_nxt_s    = {fetch_word_s[15:12], fetch_word_s[7:0]};
        pc_nxt_s    = pc_r + PCW'(1'b1);
        state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt_s = ST_FETCH;
        case (opcode_s)
          OP_NOP:  acc_nxt_s = acc_r;
          OP_LDI:  acc_nxt_s = {{(DW-8){1'b0}}, oper_s};
          OP_LD:   acc_nxt_s = dmem_rd_s;
          OP_ST:   dmem_we_s = 1'b1;
          OP_ADD:  acc_nxt_s = acc_r + dmem_rd_s;
          OP_SUB:  acc_nxt_s = acc_r - dmem_rd_s;
          OP_AND:  acc_nxt_s = acc_r & dmem_rd_s;
          OP_OR:   acc_nxt_s = acc_r | dmem_rd_s;
          OP_XOR:  acc_nxt_s = acc_r ^ dmem_rd_s;
          OP_JMP:  pc_nxt_s  = oper_s[PCW-1:0];
          OP_JZ: begin
            if (acc_r == {DW{1'b0}}) begin
              pc_nxt_s = oper_s[PCW-1:0];
            end else begin
              pc_nxt_s = pc_r;
            end
          end
          OP_JN: begin
            if (acc_r[DW-1]) begin
              pc_nxt_s = oper_s[PCW-1:0];
            end else begin
              pc_nxt_s = pc_r;
            end
          end
          OP_ADDI: acc_nxt_s = acc_r + {{(DW-8){1'b0}}, oper_s};
          OP_SHL:  acc_nxt_s = {acc_r[DW-2:0], 1'b0};
          OP_SHR:  acc_nxt_s = {1'b0, acc_r[DW-1:1]};
          OP_HLT:  state_nxt_s = ST_HALT;
          default: acc_nxt_s = acc_r;
        endcase
      end
      ST_HALT: begin
        if (!start_sig) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control and architectural registers; busy/done follow the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      pc_r    <= {PCW{1'b0}};
      acc_r   <= {DW{1'b0}};
      ir_r    <= 12'h000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      acc_r   <= acc_nxt_s;
      ir_r    <= ir_nxt_s;
      busy_r  <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_EXEC);
      done_r  <= (state_nxt_s == ST_HALT);
    end
  end

  // Instruction memory: reloads the built-in program on reset, loadable when stopped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        imem_r[i] <= default_word(i);
      end
    end else if (imem_we && imem_wr_ok_s) begin
      imem_r[imem_waddr] <= imem_wdata;
    end
  end

  // Data memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (dmem_we_s) begin
      dmem_r[oper_s] <= acc_r;
    end
  end

  assign dbg_data = dmem_r[dbg_addr];
  assign busy     = busy_r;
  assign done     = done_r;
  assign pc       = pc_r;
  assign acc      = acc_r;

endmodule

// File: tb/tb_cpu_hlr.sv
// Scoreboard bench for cpu_hlr: each run queues its expected halt state,
// and a monitor checks it when done rises.
module tb_cpu_hlr;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_sig;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        busy;
  logic        done;
  logic [4:0]  pc;
  logic [15:0] acc;

  cpu_hlr dut (
    .clk        (clk),
    .rst        (rst),
    .start_sig  (start_sig),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .busy       (busy),
    .done       (done),
    .pc         (pc),
    .acc        (acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] acc;
    logic [4:0]  pc;
    int          cycles;
    logic [15:0] dbg;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: cycles counted from the edge that leaves IDLE; checks on done rising.
  logic done_q = 1'b0;
  logic busy_q = 1'b0;
  int   run_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_q) run_cyc = 0;
    else run_cyc++;
    if (done && !done_q) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_acc"}, {16'h0, acc}, {16'h0, e.acc});
        check({e.name, "_pc"}, {27'h0, pc}, {27'h0, e.pc});
        check({e.name, "_cycles"}, run_cyc, e.cycles);
        check({e.name, "_dmem"}, {16'h0, dbg_data}, {16'h0, e.dbg});
      end
    end
    done_q = done;
    busy_q = busy;
  end

  task automatic load(input logic [4:0] a, input logic [15:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    @(negedge clk);
    imem_we    = 1'b0;
  endtask

  // Wait for done with a cycle budget; optionally pulse imem_we while busy.
  task automatic wait_done(input string name, input int limit, input bit poke);
    int k = 0;
    while (!done && k < limit) begin
      @(negedge clk);
      k++;
      imem_we    = poke && (k >= 10) && (k < 14);
      imem_waddr = 5'd15;
      imem_wdata = 16'h0000;
    end
    imem_we = 1'b0;
    if (!done) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input exp_t e, input int limit, input bit poke);
    sb_q.push_back(e);
    start_sig = 1'b1;
    wait_done(e.name, limit, poke);
  endtask

  task automatic go_idle();
    start_sig = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'h0, busy}, 32'd0);
    check("idle_done", {31'h0, done}, 32'd0);
  endtask

  exp_t e_def;
  initial begin
    bit  wrap_seen;
    bit  busy_low;
    int  k;
    logic [4:0] prev_pc;

    e_def = '{name: "default", acc: 16'h0037, pc: 5'd16, cycles: 174, dbg: 16'h0037};
    rst = 1'b0; start_sig = 1'b0; imem_we = 1'b0;
    imem_waddr = 5'd0; imem_wdata = 16'h0000; dbg_addr = 8'h10;
    #2;
    check("rst_pc", {27'h0, pc}, 32'd0);
    check("rst_acc", {16'h0, acc}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);

    // Default program from reset.
    @(negedge clk);
    rst = 1'b1;
    start_sig = 1'b1;
    sb_q.push_back(e_def);
    @(negedge clk);
    check("start_busy", {31'h0, busy}, 32'd1);
    wait_done("default", 300, 1'b0);
    dbg_addr = 8'h11;
    @(negedge clk);
    check("default_i", {16'h0, dbg_data}, 32'd0);

    // Held start keeps HALT; a one-cycle drop returns to IDLE.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_done", {31'h0, done}, 32'd1);
      check("hold_busy", {31'h0, busy}, 32'd0);
    end
    go_idle();

    // Rerun while poking imem (HLT slot) during busy: must be ignored.
    dbg_addr = 8'h10;
    e_def.name = "rerun";
    run(e_def, 300, 1'b1);
    go_idle();

    // LDI 5, ADDI 3, SHL, ST 0x20, HLT.
    load(5'd0, 16'h1005); load(5'd1, 16'hC003); load(5'd2, 16'hD000);
    load(5'd3, 16'h3020); load(5'd4, 16'hF000);
    dbg_addr = 8'h20;
    run('{name: "progA", acc: 16'h0010, pc: 5'd5, cycles: 10, dbg: 16'h0010}, 40, 1'b0);
    go_idle();

    // 0x80 shifted left 8 times sets bit 15, so JN is taken.
    load(5'd0, 16'h1080);
    for (int i = 1; i <= 8; i++) load(5'(i), 16'hD000);
    load(5'd9, 16'h0000); load(5'd10, 16'hB00C); load(5'd11, 16'hF000);
    load(5'd12, 16'h1001); load(5'd13, 16'hF000);
    run('{name: "progJN", acc: 16'h0001, pc: 5'd14, cycles: 26, dbg: 16'h0010}, 60, 1'b0);
    go_idle();

    // 0 - dmem[0x12] (=1) wraps to 0xFFFF.
    load(5'd0, 16'h1000); load(5'd1, 16'h5012); load(5'd2, 16'hF000);
    dbg_addr = 8'h12;
    run('{name: "progSUB", acc: 16'hFFFF, pc: 5'd3, cycles: 6, dbg: 16'h0001}, 30, 1'b0);
    go_idle();

    // All-NOP program: pc must wrap 31->0 and busy stays high.
    for (int i = 0; i < 32; i++) load(5'(i), 16'h0000);
    start_sig = 1'b1;
    wrap_seen = 1'b0; busy_low = 1'b0; prev_pc = 5'd0;
    repeat (80) begin
      @(negedge clk);
      if (!busy) busy_low = 1'b1;
      if (prev_pc == 5'd31 && pc == 5'd0) wrap_seen = 1'b1;
      prev_pc = pc;
    end
    check("nop_wrap", {31'h0, wrap_seen}, 32'd1);
    check("nop_busy_low", {31'h0, busy_low}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_pc", {27'h0, pc}, 32'd0);
    start_sig = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Abort the default program mid-run once acc is non-zero.
    start_sig = 1'b1;
    k = 0;
    while (acc == 16'h0000 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("midrun_acc_nonzero", {31'h0, (acc != 16'h0000)}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrun_acc", {16'h0, acc}, 32'd0);
    check("midrun_pc", {27'h0, pc}, 32'd0);
    check("midrun_busy", {31'h0, busy}, 32'd0);
    start_sig = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset reloaded the default program; dmem[0x20] from progA persists.
    dbg_addr = 8'h20;
    run('{name: "reload", acc: 16'h0037, pc: 5'd16, cycles: 174, dbg: 16'h0010}, 300, 1'b0);
    go_idle();

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
